// File: rtl/sample_serializer.sv
// sample_serializer
//   Splits an accepted 32-bit sample word into four byte groups and hands the
//   groups that are not disabled to tuart_tx one byte at a time, lowest
//   group first.
//
// Ports
//   clk_i             system clock, rising edge
//   rst_in            asynchronous active-low reset
//   data_i[31:0]      sample word, group g = bits [8g+7:8g]
//   stb_i             word valid, accepted when stb_i && rdy_o
//   rdy_o             idle and able to accept a word (decoded from state)
//   disabled_groups_i bit g set skips group g, sampled at acceptance
//   tx_data_o[7:0]    byte to tuart_tx, held until the next strobe
//   tx_stb_o          one-cycle strobe marking tx_data_o valid
//   tx_rdy_i          tuart_tx idle and able to take a byte

module sample_serializer (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic [31:0] data_i,
  input  logic        stb_i,
  output logic        rdy_o,
  input  logic [3:0]  disabled_groups_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_stb_o,
  input  logic        tx_rdy_i
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  // Latched mask kept in inverted form: bit g set = group g still to send.
  // Sent groups are cleared, so "any group remains" is simply pend_q != 0.
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  pend_after;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  tx_data_d;
  logic        tx_stb_d;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    if (m[0])      lowest_set = 2'd0;
    else if (m[1]) lowest_set = 2'd1;
    else if (m[2]) lowest_set = 2'd2;
    else           lowest_set = 2'd3;
  endfunction

  assign rdy_o = (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    pend_d     = pend_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data_o;
    tx_stb_d   = 1'b0;
    pend_after = pend_q & ~(4'b0001 << ptr_q);

    case (state_q)
      IDLE: begin
        if (stb_i) begin
          word_d = data_i;
          pend_d = ~disabled_groups_i;
          ptr_d  = lowest_set(~disabled_groups_i);
          if (disabled_groups_i != '1)
            state_d = SEND;
        end
      end
      SEND: begin
        if (tx_rdy_i) begin
          tx_data_d = word_q[{ptr_q, 3'b000} +: 8];
          tx_stb_d  = 1'b1;
          pend_d    = pend_after;
          ptr_d     = lowest_set(pend_after);
          state_d   = HOLD;
        end
      end
      HOLD: begin
        state_d = (pend_q != '0) ? SEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      word_q    <= '0;
      pend_q    <= '0;
      ptr_q     <= '0;
      tx_data_o <= '0;
      tx_stb_o  <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      pend_q    <= pend_d;
      ptr_q     <= ptr_d;
      tx_data_o <= tx_data_d;
      tx_stb_o  <= tx_stb_d;
    end
  end

endmodule

// File: tb/tb_sample_serializer.sv
// tb_sample_serializer
//   Scoreboard bench for sample_serializer. Stimulus pushes hand-computed
//   bytes into a queue; a monitor pops and compares on every tx strobe.
//   A small tuart_tx model drops tx_rdy_i for a few cycles after each strobe.

module tb_sample_serializer;

  logic        clk_i = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] data_i = '0;
  logic        stb_i = 1'b0;
  logic        rdy_o;
  logic [3:0]  disabled_groups_i = '0;
  logic [7:0]  tx_data_o;
  logic        tx_stb_o;
  logic        tx_rdy_i = 1'b1;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int busy = 0;
  bit stall = 1'b0;
  bit prev_stb = 1'b0;
  logic [7:0] exp_q[$];

  sample_serializer dut (
    .clk_i            (clk_i),
    .rst_in           (rst_in),
    .data_i           (data_i),
    .stb_i            (stb_i),
    .rdy_o            (rdy_o),
    .disabled_groups_i(disabled_groups_i),
    .tx_data_o        (tx_data_o),
    .tx_stb_o         (tx_stb_o),
    .tx_rdy_i         (tx_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // tuart_tx model: busy for 3 cycles after sampling a strobe
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (tx_stb_o) busy = 3;
      else if (busy > 0) busy--;
      tx_rdy_i = (busy == 0) && !stall;
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_in && tx_stb_o) begin
        strobe_cnt++;
        check("stb_width", {31'd0, prev_stb}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_data_o);
        end else begin
          check("tx_byte", {24'd0, tx_data_o}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_stb = tx_stb_o;
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [3:0] m);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_i);
      if (rdy_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got rdy_o=0 expected 1");
    end
    data_i = d;
    disabled_groups_i = m;
    stb_i = 1'b1;
    @(posedge clk_i);
    #1;
    stb_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_i);
      #2;
      if (exp_q.size() == 0 && rdy_o && !tx_stb_o) begin done = 1'b1; break; end
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int base;
    // Power-on reset
    #23;
    check("reset_rdy", {31'd0, rdy_o}, 32'd1);
    check("reset_stb", {31'd0, tx_stb_o}, 32'd0);
    check("reset_data", {24'd0, tx_data_o}, 32'd0);
    @(negedge clk_i);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_i);

    // All groups enabled, with first-strobe latency check
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
    base = strobe_cnt;
    send_word(32'hDEADBEEF, 4'b0000);
    @(negedge clk_i); #1;
    check("busy_after_accept", {31'd0, rdy_o}, 32'd0);
    check("no_stb_at_e0", {31'd0, tx_stb_o}, 32'd0);
    @(negedge clk_i); #1;
    check("first_stb_latency", {31'd0, tx_stb_o}, 32'd1);
    check("first_byte", {24'd0, tx_data_o}, 32'hEF);
    wait_idle("deadbeef_done");
    check("deadbeef_count", strobe_cnt - base, 32'd4);

    // Partial mask: groups 1 and 3 only
    exp_q.push_back(8'h33); exp_q.push_back(8'h11);
    base = strobe_cnt;
    send_word(32'h11223344, 4'b0101);
    wait_idle("partial_done");
    check("partial_count", strobe_cnt - base, 32'd2);

    // Full mask: dropped, next word accepted on the following edge
    base = strobe_cnt;
    send_word(32'hAABBCCDD, 4'b1111);
    check("fullmask_rdy", {31'd0, rdy_o}, 32'd1);
    exp_q.push_back(8'h88);
    send_word(32'h55667788, 4'b1110);
    check("next_word_accepted", {31'd0, rdy_o}, 32'd0);
    wait_idle("fullmask_done");
    check("fullmask_count", strobe_cnt - base, 32'd1);

    // Backpressure with an ignored stb_i during the stall
    stall = 1'b1;
    tx_rdy_i = 1'b0;
    exp_q.push_back(8'h78); exp_q.push_back(8'h56);
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    send_word(32'h12345678, 4'b0000);
    base = strobe_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (i == 5) begin
        data_i = 32'h9ABCDEF0;
        disabled_groups_i = 4'b0000;
        stb_i = 1'b1;
      end else begin
        stb_i = 1'b0;
      end
    end
    check("stall_no_strobe", strobe_cnt - base, 32'd0);
    #1;
    stall = 1'b0;
    tx_rdy_i = 1'b1;
    @(negedge clk_i); #1;
    check("stall_release_stb", {31'd0, tx_stb_o}, 32'd1);
    check("stall_byte0", {24'd0, tx_data_o}, 32'h78);
    wait_idle("stall_done");
    check("stall_count", strobe_cnt - base, 32'd4);

    // Reset after second strobe of CAFEF00D
    exp_q.push_back(8'h0D); exp_q.push_back(8'hF0);
    base = strobe_cnt;
    send_word(32'hCAFEF00D, 4'b0000);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i); #1;
      if (strobe_cnt - base >= 2) break;
    end
    check("reset_mid_two", strobe_cnt - base, 32'd2);
    rst_in = 1'b0;
    #1;
    check("midreset_rdy", {31'd0, rdy_o}, 32'd1);
    check("midreset_stb", {31'd0, tx_stb_o}, 32'd0);
    check("midreset_data", {24'd0, tx_data_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_in = 1'b1;
    repeat (10) @(negedge clk_i);
    check("no_strobe_after_reset", strobe_cnt - base, 32'd2);

    exp_q.push_back(8'h04); exp_q.push_back(8'h03);
    exp_q.push_back(8'h02); exp_q.push_back(8'h01);
    send_word(32'h01020304, 4'b0000);
    wait_idle("post_reset_done");
    check("post_reset_count", strobe_cnt - base, 32'd6);

    repeat (10) @(negedge clk_i);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sample_serializer.md
# sample_serializer

Feeds the UART transmitter with captured samples. Accepts one 32-bit sample word per handshake, splits it into four byte groups, skips the groups disabled by the host configuration, and presents the remaining bytes one at a time, least-significant group first, on the `tuart_tx` byte interface. It sits directly upstream of `tuart_tx`, between the sample memory read-out and the serial line.

## Interface
- No parameters: the word is fixed at 32 bits in 4 groups of 8 bits.
- `clk_i`  in  1  system clock; all registers update on the rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `data_i`  in  32  sample word; group g is bits [8g+7:8g].
- `stb_i`  in  1  word valid; the word is accepted at a rising edge where `stb_i && rdy_o`.
- `rdy_o`  out  1  high while idle and able to accept a word.
- `disabled_groups_i`  in  4  bit g set means group g is not transmitted; sampled only at acceptance.
- `tx_data_o`  out  8  byte to `tuart_tx`.
- `tx_stb_o`  out  1  one-cycle strobe marking `tx_data_o` valid.
- `tx_rdy_i`  in  1  `tuart_tx` is idle and can take a byte.

## Operation
- FSM states: IDLE, SEND, HOLD. `rdy_o` = (state == IDLE), decoded combinationally from the state register.
- **IDLE**
  - On accept, latch `data_i` and `disabled_groups_i` into internal registers.
  - If the latched mask is 4'b1111, drop the word and stay in IDLE. No bytes are sent.
  - Otherwise, set the group pointer to the lowest enabled group and go to SEND.
- **SEND**
  - If `tx_rdy_i` is 1 at the edge: register `tx_data_o` = latched byte[pointer] and `tx_stb_o` = 1, advance the pointer to the next higher enabled group, and go to HOLD.
  - If `tx_rdy_i` is 0, wait indefinitely. Outputs are unchanged and `tx_stb_o` stays 0.
- **HOLD** (exactly one cycle, `tx_rdy_i` ignored)
  - `tx_stb_o` returns to 0.
  - Go to SEND if an enabled group remains, else go to IDLE.
  - HOLD guarantees that `tuart_tx` has dropped `tx_rdy_i` before the next ready check.
- Byte order: ascending group index; disabled groups are skipped without consuming cycles.
- `tx_data_o` holds the last byte sent until the next strobe.
- `stb_i` while `rdy_o` = 0 is ignored. There is no buffering; the upstream stage must hold or retry.
- Changes to `data_i` or `disabled_groups_i` after acceptance have no effect on the word in flight.
- **Reset:** asynchronous assertion forces state IDLE, `rdy_o` = 1, `tx_stb_o` = 0, `tx_data_o` = 8'h00, and clears the latched word, mask and pointer. A word in flight is discarded with no further strobes.

## Timing
- Accept at edge E0 leads to the earliest first strobe high in the cycle after edge E1. Latency is 1 cycle when `tx_rdy_i` = 1.
- `tx_stb_o` is high for exactly one cycle per byte.
- Minimum spacing between strobes is 2 cycles. Actual spacing is set by `tx_rdy_i`.
- After the final byte's strobe (high after E1), state is IDLE and `rdy_o` = 1 after edge E2.
- A word with n enabled groups produces exactly n strobes, n in 0..4.
- The `tuart_tx` contract is that `tx_rdy_i` deasserts in the cycle after it samples `tx_stb_o`, and reasserts only when the line is free.
- All outputs are registered except `rdy_o`, which is decoded from the state register and glitch-free.

## Test plan
- **Reset:** drive `rst_in` = 0 mid-simulation, with no clock edge required -> `rdy_o` = 1, `tx_stb_o` = 0, `tx_data_o` = 8'h00 immediately.
- **All groups enabled:** `data_i` = 32'hDEADBEEF, mask 4'b0000, UART model always ready after its busy period -> 4 strobes with bytes EF, BE, AD, DE in that order. `rdy_o` is low from E0+ until after the last strobe, and the scoreboard sees exactly 4 bytes.
- **Partial mask:** `data_i` = 32'h11223344, mask 4'b0101 -> bytes 33, 11 only.
- **Full mask:** mask 4'b1111 with any data -> no strobe, `rdy_o` stays 1, and the next word is accepted on the following edge.
- **Backpressure:** hold `tx_rdy_i` = 0 for 20 cycles after accept -> no strobe during the stall. Raising `tx_rdy_i` gives a strobe one edge later with byte 0 intact. A second `stb_i` pulse during the stall is ignored.
- **Reset mid-word:** assert reset after the 2nd strobe of 32'hCAFEF00D -> no further strobes. After release, 32'h01020304 with mask 4'b0000 produces 04, 03, 02, 01.
